// File: rtl/riscv_cpu_pkg.sv
// Shared types and constants for the ID-stage hazard sequencer and its scoreboard.
package riscv_cpu_pkg;

    localparam int ADDR_WIDTH        = 5;
    localparam int HAZARD_PIPE_DEPTH = 3;
    // Slots at or below this index hold instructions younger than the branch resolved in MEM.
    localparam int HAZARD_MEM_SLOT   = 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] waddr;
    } sb_entry_t;

    // An operand only matters if it is actually read and is not the hardwired x0.
    function automatic logic operand_hazard(input logic                  use_flag,
                                            input logic [ADDR_WIDTH-1:0] raddr,
                                            input logic                  hit);
        return use_flag && (raddr != '0) && hit;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage <-> hazard sequencer signal bundle; master is the pipeline, slave is hazard_ctrl.
interface hazard_ctrl_if;

    logic                                id_valid_i;
    logic [riscv_cpu_pkg::ADDR_WIDTH-1:0] id_raddr_a_i;
    logic                                id_use_a_i;
    logic [riscv_cpu_pkg::ADDR_WIDTH-1:0] id_raddr_b_i;
    logic                                id_use_b_i;
    logic                                id_we_i;
    logic [riscv_cpu_pkg::ADDR_WIDTH-1:0] id_waddr_i;
    logic                                jal_op_i;
    logic                                branch_taken_i;

    logic                                if_stall_o;
    logic                                id_stall_o;
    logic                                if_flush_o;
    logic                                ex_bubble_o;
    logic                                ex_flush_o;
    logic [1:0]                          state_o;

    modport master (
        output id_valid_i, id_raddr_a_i, id_use_a_i, id_raddr_b_i, id_use_b_i,
               id_we_i, id_waddr_i, jal_op_i, branch_taken_i,
        input  if_stall_o, id_stall_o, if_flush_o, ex_bubble_o, ex_flush_o, state_o
    );

    modport slave (
        input  id_valid_i, id_raddr_a_i, id_use_a_i, id_raddr_b_i, id_use_b_i,
               id_we_i, id_waddr_i, jal_op_i, branch_taken_i,
        output if_stall_o, id_stall_o, if_flush_o, ex_bubble_o, ex_flush_o, state_o
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of destination registers in flight in EX, MEM and WB.
module hazard_scoreboard
    import riscv_cpu_pkg::*;
#(
    parameter int PIPE_DEPTH = HAZARD_PIPE_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_en,
    input  logic                  push_we,
    input  logic [ADDR_WIDTH-1:0] push_waddr,
    input  logic                  invalidate,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic                  match_a,
    output logic                  match_b
);

    sb_entry_t             sb_reg [PIPE_DEPTH];
    sb_entry_t             push_entry;
    logic [PIPE_DEPTH-1:0] hit_a;
    logic [PIPE_DEPTH-1:0] hit_b;

    assign push_entry.valid = push_we && (push_waddr != '0);
    assign push_entry.waddr = push_waddr;

    // The MEM occupant on a taken branch is the branch itself, so it retires normally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb_reg[i] <= '0;
            end
        end else begin
            sb_reg[0] <= push_en ? push_entry : '0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sb_reg[i] <= (invalidate && (i <= HAZARD_MEM_SLOT)) ? '0 : sb_reg[i-1];
            end
        end
    end

    for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_match
        assign hit_a[gi] = sb_reg[gi].valid && (sb_reg[gi].waddr == raddr_a);
        assign hit_b[gi] = sb_reg[gi].valid && (sb_reg[gi].waddr == raddr_b);
    end

    assign match_a = |hit_a;
    assign match_b = |hit_b;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage stall/flush sequencer (no forwarding). Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import riscv_cpu_pkg::*;
#(
    parameter int PIPE_DEPTH = HAZARD_PIPE_DEPTH
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH  = 32
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    hazard_ctrl_if.slave         ctrl
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
`endif
);

    hazard_state_e state_reg;
    logic          match_a;
    logic          match_b;
    logic          branch;
    logic          in_flush;
    logic          hazard_raw;
    logic          hazard;
    logic          jump;
    logic          push_en;
    logic          if_stall;
    logic          id_stall;
    logic          if_flush;
    logic          ex_bubble;
    logic          ex_flush;

    assign branch     = ctrl.branch_taken_i;
    assign in_flush   = (state_reg == FLUSH);
    assign hazard_raw = ctrl.id_valid_i &&
                        (operand_hazard(ctrl.id_use_a_i, ctrl.id_raddr_a_i, match_a) ||
                         operand_hazard(ctrl.id_use_b_i, ctrl.id_raddr_b_i, match_b));
    // The ID instruction during FLUSH is wrong-path, so neither its hazard nor its jump counts.
    assign hazard     = hazard_raw && !in_flush && !branch;
    assign jump       = ctrl.jal_op_i && !in_flush && !branch && !hazard;
    assign push_en    = ctrl.id_valid_i && !hazard && !branch && !in_flush;

    hazard_scoreboard #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_en    (push_en),
        .push_we    (ctrl.id_we_i),
        .push_waddr (ctrl.id_waddr_i),
        .invalidate (branch),
        .raddr_a    (ctrl.id_raddr_a_i),
        .raddr_b    (ctrl.id_raddr_b_i),
        .match_a    (match_a),
        .match_b    (match_b)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= RUN;
        end else begin
            case (state_reg)
                RUN: begin
                    if (branch)      state_reg <= FLUSH;
                    else if (hazard) state_reg <= STALL;
                end
                STALL: begin
                    if (branch)       state_reg <= FLUSH;
                    else if (!hazard) state_reg <= RUN;
                end
                FLUSH:   state_reg <= branch ? FLUSH : RUN;
                default: state_reg <= RUN;
            endcase
        end
    end

    // Decode follows the live hazard so the stall drops in the very cycle it clears.
    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        if_flush  = 1'b0;
        ex_bubble = 1'b0;
        ex_flush  = 1'b0;
        if (rst_ni) begin
            if (branch) begin
                if_flush  = 1'b1;
                ex_bubble = 1'b1;
                ex_flush  = 1'b1;
            end else if (in_flush) begin
                ex_bubble = 1'b1;
            end else if (hazard) begin
                if_stall  = 1'b1;
                id_stall  = 1'b1;
                ex_bubble = 1'b1;
            end else if (jump) begin
                if_flush  = 1'b1;
            end
        end
    end

    assign ctrl.if_stall_o  = if_stall;
    assign ctrl.id_stall_o  = id_stall;
    assign ctrl.if_flush_o  = if_flush;
    assign ctrl.ex_bubble_o = ex_bubble;
    assign ctrl.ex_flush_o  = ex_flush;
    assign ctrl.state_o     = state_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_reg;
    logic [CNT_WIDTH-1:0] flush_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (id_stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
            if (if_flush && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected outputs are hand-derived per cycle.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] waddr;
        logic       use_a;
        logic [4:0] ra;
        logic       use_b;
        logic [4:0] rb;
        logic       jal;
        logic       br;
    } stim_t;

    // Observed vector: {if_stall, id_stall, if_flush, ex_bubble, ex_flush, state[1:0]}
    localparam logic [6:0] O_RUN     = 7'b00000_00;
    localparam logic [6:0] O_HZ_RUN  = 7'b11010_00;
    localparam logic [6:0] O_HZ_STL  = 7'b11010_01;
    localparam logic [6:0] O_STL_CLR = 7'b00000_01;
    localparam logic [6:0] O_JAL_RUN = 7'b00100_00;
    localparam logic [6:0] O_JAL_STL = 7'b00100_01;
    localparam logic [6:0] O_BR_RUN  = 7'b00111_00;
    localparam logic [6:0] O_BR_STL  = 7'b00111_01;
    localparam logic [6:0] O_FLUSH   = 7'b00010_10;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    hazard_ctrl_if bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    hazard_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ctrl        (bus),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );
`else
    hazard_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ctrl   (bus)
    );
`endif

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {bus.if_stall_o, bus.id_stall_o, bus.if_flush_o, bus.ex_bubble_o,
                bus.ex_flush_o, bus.state_o};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // ADDI x0,x0,0
    function automatic stim_t nop();
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.we    = 1'b1;
        s.use_a = 1'b1;
        return s;
    endfunction

    function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.we    = 1'b1;
        s.waddr = rd;
        s.use_a = 1'b1;
        s.ra    = rs1;
        s.use_b = 1'b1;
        s.rb    = rs2;
        return s;
    endfunction

    function automatic stim_t addi(input logic [4:0] rd, input logic [4:0] rs1);
        stim_t s;
        s = alu(rd, rs1, 5'd0);
        s.use_b = 1'b0;
        return s;
    endfunction

    // LUI with stale register fields that must be ignored.
    function automatic stim_t lui_junk(input logic [4:0] rd);
        stim_t s;
        s = alu(rd, rd, rd);
        s.use_a = 1'b0;
        s.use_b = 1'b0;
        return s;
    endfunction

    // Invalid slot whose fields would otherwise hit the scoreboard.
    function automatic stim_t ghost(input logic [4:0] r);
        stim_t s;
        s = alu(r, r, r);
        s.valid = 1'b0;
        return s;
    endfunction

    function automatic stim_t jal_i(input logic [4:0] rd);
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.we    = 1'b1;
        s.waddr = rd;
        s.jal   = 1'b1;
        return s;
    endfunction

    function automatic stim_t jalr_i(input logic [4:0] rd, input logic [4:0] rs1);
        stim_t s;
        s = addi(rd, rs1);
        s.jal = 1'b1;
        return s;
    endfunction

    function automatic stim_t with_br(input stim_t s_in);
        stim_t s;
        s = s_in;
        s.br = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.id_valid_i     = s.valid;
        bus.id_we_i        = s.we;
        bus.id_waddr_i     = s.waddr;
        bus.id_use_a_i     = s.use_a;
        bus.id_raddr_a_i   = s.ra;
        bus.id_use_b_i     = s.use_b;
        bus.id_raddr_b_i   = s.rb;
        bus.jal_op_i       = s.jal;
        bus.branch_taken_i = s.br;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            apply(idle());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        stim_t s;
        rst_n = 1'b0;
        s = with_br(jal_i(5'd1));
        apply(s);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== O_RUN) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", obs(), O_RUN);
        end else $display("reset_outputs out=%b", obs());
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
`endif
        apply(idle());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_dep_dist1();
        stim_t      seq[$];
        logic [6:0] exp[$];
        drain();
        seq = '{addi(5, 0), alu(6, 5, 0), alu(6, 5, 0), alu(6, 5, 0), alu(6, 5, 0), nop()};
        exp = '{O_RUN, O_HZ_RUN, O_HZ_STL, O_HZ_STL, O_STL_CLR, O_RUN};
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL dist1[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end else $display("dist1[%0d] out=%b", i, obs());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_dep_distance();
        stim_t      seq[$];
        logic [6:0] exp[$];
        for (int d = 2; d <= 4; d++) begin
            drain();
            seq = '{addi(5, 0)};
            exp = '{O_RUN};
            for (int k = 1; k < d; k++) begin
                seq.push_back(nop());
                exp.push_back(O_RUN);
            end
            // Consumer reads x5 via rs2 only, so the second match port is exercised too.
            for (int k = 0; k <= 4 - d; k++) begin
                seq.push_back(alu(6, 0, 5));
                exp.push_back(k == 0 ? ((d == 4) ? O_RUN : O_HZ_RUN)
                                     : ((k == 4 - d) ? O_STL_CLR : O_HZ_STL));
            end
            seq.push_back(nop());
            exp.push_back(O_RUN);
            foreach (seq[i]) begin
                apply(seq[i]);
                @(negedge clk);
                checks++;
                if (obs() !== exp[i]) begin
                    errors++;
                    $display("FAIL dist%0d[%0d] got=%b exp=%b", d, i, obs(), exp[i]);
                end else $display("dist%0d[%0d] out=%b", d, i, obs());
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_x0_unused();
        stim_t      seq[$];
        logic [6:0] exp[$];
        drain();
        seq = '{addi(0, 0), alu(1, 0, 0), addi(7, 0), lui_junk(7), ghost(7), nop()};
        exp = '{O_RUN, O_RUN, O_RUN, O_RUN, O_RUN, O_RUN};
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL x0_unused[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end else $display("x0_unused[%0d] out=%b", i, obs());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jal();
        stim_t      seq[$];
        logic [6:0] exp[$];
        drain();
        // JAL flushes once, and its link register x1 is still tracked.
        seq = '{jal_i(1), nop(), alu(2, 1, 0), alu(2, 1, 0), alu(2, 1, 0), nop()};
        exp = '{O_JAL_RUN, O_RUN, O_HZ_RUN, O_HZ_STL, O_STL_CLR, O_RUN};
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL jal[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end else $display("jal[%0d] out=%b", i, obs());
            @(posedge clk);
            #1;
        end
        drain();
        seq = '{addi(5, 0), jalr_i(1, 5), jalr_i(1, 5), jalr_i(1, 5), jalr_i(1, 5), nop()};
        exp = '{O_RUN, O_HZ_RUN, O_HZ_STL, O_HZ_STL, O_JAL_STL, O_RUN};
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL jalr[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end else $display("jalr[%0d] out=%b", i, obs());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        stim_t      seq[$];
        logic [6:0] exp[$];
        drain();
        // Branch during STALL; the wrong-path JALR in FLUSH must neither stall, flush nor push x1.
        seq = '{addi(5, 0), alu(6, 5, 0), with_br(alu(6, 5, 0)), jalr_i(1, 5),
                alu(6, 5, 0), alu(7, 1, 0)};
        exp = '{O_RUN, O_HZ_RUN, O_BR_STL, O_FLUSH, O_RUN, O_RUN};
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL br_stall[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end else $display("br_stall[%0d] out=%b", i, obs());
            @(posedge clk);
            #1;
        end
        drain();
        // Branch in RUN beats a pending hazard and a jump; x5 in EX is squashed.
        seq = '{addi(5, 0), with_br(jalr_i(1, 5)), nop(), alu(6, 5, 0), nop()};
        exp = '{O_RUN, O_BR_RUN, O_FLUSH, O_RUN, O_RUN};
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL br_run[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end else $display("br_run[%0d] out=%b", i, obs());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t      seq[$];
        logic [6:0] exp[$];
        drain();
        seq = '{jal_i(1), jal_i(3), addi(5, 0), alu(6, 5, 0), alu(6, 5, 0), alu(6, 5, 0),
                alu(6, 5, 0), alu(7, 6, 0), alu(7, 6, 0), alu(7, 6, 0), alu(7, 6, 0), nop()};
        exp = '{O_JAL_RUN, O_JAL_RUN, O_RUN, O_HZ_RUN, O_HZ_STL, O_HZ_STL, O_STL_CLR,
                O_HZ_RUN, O_HZ_STL, O_HZ_STL, O_STL_CLR, O_RUN};
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got=%b exp=%b", i, obs(), exp[i]);
            end else $display("b2b[%0d] out=%b", i, obs());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        apply(addi(5, 0));
        @(posedge clk);
        #1;
        apply(alu(6, 5, 0));
        @(negedge clk);
        checks++;
        if (obs() !== O_HZ_RUN) begin
            errors++;
            $display("FAIL pre_reset_stall got=%b exp=%b", obs(), O_HZ_RUN);
        end else $display("pre_reset_stall out=%b", obs());
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== O_RUN) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", obs(), O_RUN);
        end else $display("async_reset out=%b", obs());
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== O_RUN) begin
            errors++;
            $display("FAIL post_reset_no_stale got=%b exp=%b", obs(), O_RUN);
        end else $display("post_reset_no_stale out=%b", obs());
        @(posedge clk);
        #1;
        apply(idle());
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        errors = 0;
        checks = 0;
        apply(idle());
        test_reset();
        test_dep_dist1();
        test_dep_distance();
        test_x0_unused();
        test_jal();
        test_branch();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
